fetch_sequencer: RTL

- Instruction-fetch controller for the single-cycle CPU's 4096-word instruction memory.
- Owns the program counter and drives the memory's 12-bit word address.
- Captures returned instructions into a 2-entry queue and hands them to decode with a valid/ready handshake.
- Handles branch/jump redirects by flushing the queue, and halts with a sticky fault on a bad PC.

---
 rtl/fetch_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, fetches from a 4096-word memory into a
// small in-order queue for decode. Optional counters enabled with FETCH_PERF_EN.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [11:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc,
    output logic        fault
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stalls
`endif
);

    localparam int CW = $clog2(QDEPTH) + 1;

    typedef enum logic {
        RUN,
        HALT
    } state_t;

    state_t              state_reg;
    logic [31:0]         pc_reg;
    logic                fault_reg;
    logic [CW-1:0]       count_reg;
    logic [QDEPTH-1:0][31:0] q_inst_reg;
    logic [QDEPTH-1:0][31:0] q_pc_reg;
    logic [QDEPTH-1:0][31:0] q_inst_next;
    logic [QDEPTH-1:0][31:0] q_pc_next;

    logic          pc_legal;
    logic          in_run;
    logic          pop;
    logic          flush;
    logic          full;
    logic          push;
    logic [CW-1:0] wr_idx;

    assign pc_legal = (pc_reg[1:0] == 2'b00) && (pc_reg[31:14] == 18'd0);
    assign in_run   = (state_reg == RUN);
    assign pop      = inst_valid && inst_ready;
    assign flush    = in_run && redirect_valid;
    assign full     = (count_reg == CW'(QDEPTH));
    assign push     = in_run && !redirect_valid && pc_legal && (!full || pop);
    // A simultaneous pop shifts everything down, so the tail slot moves with it.
    assign wr_idx   = count_reg - CW'(pop);

    assign imem_addr  = pc_reg[13:2];
    assign inst_valid = (count_reg != '0);
    assign inst_out   = q_inst_reg[0];
    assign inst_pc    = q_pc_reg[0];
    assign fault      = fault_reg;

    // Shift-register queue: slot 0 is the head, so an emptied queue keeps showing its last entry.
    generate
        for (genvar gi = 0; gi < QDEPTH; gi++) begin : gen_entry
            logic [31:0] shift_inst;
            logic [31:0] shift_pc;
            logic        wr_here;
            logic        shift_here;

            if (gi < QDEPTH - 1) begin : g_shift
                assign shift_inst = q_inst_reg[gi+1];
                assign shift_pc   = q_pc_reg[gi+1];
            end else begin : g_last
                assign shift_inst = q_inst_reg[gi];
                assign shift_pc   = q_pc_reg[gi];
            end

            assign wr_here    = push && (wr_idx == CW'(gi));
            assign shift_here = pop && (CW'(gi + 1) < count_reg);

            assign q_inst_next[gi] = wr_here    ? imem_data  :
                                     shift_here ? shift_inst : q_inst_reg[gi];
            assign q_pc_next[gi]   = wr_here    ? pc_reg     :
                                     shift_here ? shift_pc   : q_pc_reg[gi];
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg  <= RUN;
            pc_reg     <= RESET_PC;
            fault_reg  <= 1'b0;
            count_reg  <= '0;
            q_inst_reg <= '0;
            q_pc_reg   <= '0;
        end else begin
            q_inst_reg <= q_inst_next;
            q_pc_reg   <= q_pc_next;
            if (flush) begin
                count_reg <= '0;
                pc_reg    <= redirect_pc;
            end else begin
                count_reg <= count_reg + CW'(push) - CW'(pop);
                if (push) begin
                    pc_reg <= pc_reg + 32'd4;
                end
                if (in_run && !pc_legal) begin
                    state_reg <= HALT;
                    fault_reg <= 1'b1;
                end
            end
        end
    end

`ifdef FETCH_PERF_EN
    logic stall;

    assign stall = in_run && !redirect_valid && pc_legal && full && !pop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
        end else begin
            if (push && (perf_fetched != 32'hFFFF_FFFF)) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (stall && (perf_stalls != 32'hFFFF_FFFF)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end
`endif

endmodule
